// File: rtl/buz_alarm_arbiter.sv
// buz_alarm_arbiter
//   Fixed-priority scheduler in front of the shared piezo buzzer. Each rising
//   edge on a request source becomes one pending event. One event is served at
//   a time: a single-cycle ALARM pulse, then a hold window that covers the full
//   buzzer pattern, then a silent gap before the next source may be served.
//
// Ports
//   CLK1K     in   1 kHz clock, rising edge
//   RSTN      in   asynchronous active-low reset
//   REQ       in   [NREQ] request levels; 0->1 is an event
//   MASK      in   [NREQ] 1 = source disabled (edges ignored, pending cleared)
//   FLUSH     in   clear all pending bits this cycle (running alarm unaffected)
//   ALARM     out  one-cycle trigger to the buzzer block
//   GRANT     out  [NREQ] one-hot source being served (FIRE/HOLD only)
//   BUSY      out  FSM not in IDLE
//   PENDING   out  [NREQ] registered pending-event flags
//   DROP_CNT  out  [8] saturating count of cycles with an event on a pending source
module buz_alarm_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 4100,
  parameter int GAP_CYCLES  = 250,
  parameter int TW          = 13
) (
  input  logic            CLK1K,
  input  logic            RSTN,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] MASK,
  input  logic            FLUSH,
  output logic            ALARM,
  output logic [NREQ-1:0] GRANT,
  output logic            BUSY,
  output logic [NREQ-1:0] PENDING,
  output logic [7:0]      DROP_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_HOLD, S_GAP} state_e;

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            alarm_q, alarm_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] req_q;
  logic [7:0]      drop_q, drop_d;

  logic [NREQ-1:0] rise, pick, clr_g;

  // req_q resets to 0, so a level already high at the first clock is an edge.
  assign rise = REQ & ~req_q & ~MASK;
  // Lowest set bit = highest priority (two's complement isolate).
  assign pick = pend_q & (~pend_q + NREQ'(1));

  // State register
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (|pend_q) state_d = S_FIRE;
      S_FIRE: state_d = S_HOLD;
      S_HOLD: if (timer_q == '0) state_d = S_GAP;
      S_GAP:  if (timer_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs / datapath. ALARM and GRANT are computed one cycle ahead so they
  // leave as flops aligned with the FIRE state.
  always_comb begin
    timer_d = timer_q;
    grant_d = grant_q;
    alarm_d = 1'b0;
    clr_g   = '0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|pend_q) begin
          clr_g   = pick;
          grant_d = pick;
          alarm_d = 1'b1;
        end
      end
      S_FIRE: timer_d = HOLD_LD;
      S_HOLD: begin
        if (timer_q == '0) begin
          grant_d = '0;
          timer_d = GAP_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GAP: if (timer_q != '0) timer_d = timer_q - 1'b1;
      default: begin
        grant_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // A rise on the bit granted this cycle re-arms it as a fresh event; it is
  // excluded from the drop count via clr_g.
  always_comb begin
    pend_d = ((pend_q & ~clr_g) | rise) & ~MASK & ~{NREQ{FLUSH}};
    drop_d = drop_q;
    if ((|(rise & pend_q & ~clr_g)) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      timer_q <= '0;
      grant_q <= '0;
      alarm_q <= 1'b0;
      pend_q  <= '0;
      req_q   <= '0;
      drop_q  <= '0;
    end else begin
      timer_q <= timer_d;
      grant_q <= grant_d;
      alarm_q <= alarm_d;
      pend_q  <= pend_d;
      req_q   <= REQ;
      drop_q  <= drop_d;
    end
  end

  assign ALARM    = alarm_q;
  assign GRANT    = grant_q;
  assign BUSY     = (state_q != S_IDLE);
  assign PENDING  = pend_q;
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_buz_alarm_arbiter.sv
module tb_buz_alarm_arbiter;
  localparam int NREQ = 4;
  localparam int H    = 4100;
  localparam int G    = 250;

  logic            CLK1K, RSTN, FLUSH;
  logic [NREQ-1:0] REQ, MASK;
  logic            ALARM, BUSY;
  logic [NREQ-1:0] GRANT, PENDING;
  logic [7:0]      DROP_CNT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  buz_alarm_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(H), .GAP_CYCLES(G), .TW(13)) dut (
    .CLK1K(CLK1K), .RSTN(RSTN), .REQ(REQ), .MASK(MASK), .FLUSH(FLUSH),
    .ALARM(ALARM), .GRANT(GRANT), .BUSY(BUSY), .PENDING(PENDING), .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK1K = 1'b0;
    forever #5 CLK1K = ~CLK1K;
  end

  always @(posedge CLK1K) cyc <= cyc + 1;

  // Behavioural model: an alarm is a position in a fixed timeline
  // (0 = trigger, 1..H = hold, H+1..H+G = gap, -1 = idle).
  int              m_pos = -1;
  int              m_src = 0;
  logic [NREQ-1:0] m_pend = '0, m_reqd = '0;
  int              m_drop = 0;

  initial begin
    logic [NREQ-1:0] rise, clr;
    forever begin
      @(posedge CLK1K or negedge RSTN);
      if (!RSTN) begin
        m_pos = -1; m_src = 0; m_pend = '0; m_reqd = '0; m_drop = 0;
      end else begin
        rise = REQ & ~m_reqd & ~MASK;
        clr  = '0;
        if (m_pos < 0) begin
          if (m_pend != 0) begin
            for (int i = NREQ - 1; i >= 0; i--) if (m_pend[i]) m_src = i;
            clr = '0;
            clr[m_src] = 1'b1;
            m_pos = 0;
          end
        end else if (m_pos == H + G) begin
          m_pos = -1;
        end else begin
          m_pos = m_pos + 1;
        end
        if (((rise & m_pend & ~clr) != 0) && m_drop < 255) m_drop = m_drop + 1;
        m_pend = ((m_pend & ~clr) | rise) & ~MASK & ~{NREQ{FLUSH}};
        m_reqd = REQ;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK1K) begin
    logic            e_alarm, e_busy;
    logic [NREQ-1:0] e_grant;
    e_alarm = (m_pos == 0);
    e_busy  = (m_pos >= 0);
    e_grant = '0;
    if (m_pos >= 0 && m_pos <= H) e_grant[m_src] = 1'b1;
    total++;
    if (ALARM !== e_alarm || BUSY !== e_busy || GRANT !== e_grant ||
        PENDING !== m_pend || DROP_CNT !== 8'(m_drop)) begin
      bad++;
      $display("FAIL model_cmp cyc=%0d got a=%b g=%b b=%b p=%b d=%0d want a=%b g=%b b=%b p=%b d=%0d",
               cyc, ALARM, GRANT, BUSY, PENDING, DROP_CNT,
               e_alarm, e_grant, e_busy, m_pend, m_drop);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK1K);
    #1;
  endtask

  // Advance until ALARM is seen; returns cycles waited.
  task automatic wait_alarm(input string name, output int n);
    n = 0;
    while (ALARM !== 1'b1 && n < 6000) begin step(); n++; end
    chk({name, "_alarm_seen"}, ALARM, 1);
  endtask

  // Advance until BUSY drops; counts alarms seen on the way.
  task automatic wait_idle(input string name, output int na);
    int n;
    n = 0; na = 0;
    while (BUSY !== 1'b0 && n < 6000) begin
      step(); n++;
      if (ALARM === 1'b1) na++;
    end
    chk({name, "_idle_seen"}, BUSY, 0);
  endtask

  initial begin
    int n, na, t0;
    RSTN = 1'b0; REQ = '0; MASK = '0; FLUSH = 1'b0;
    #22 RSTN = 1'b1;

    // Reset state
    step();
    chk("rst_alarm", ALARM, 0); chk("rst_grant", GRANT, 0);
    chk("rst_busy", BUSY, 0);   chk("rst_pend", PENDING, 0);
    chk("rst_drop", DROP_CNT, 0);

    // Single request on source 2
    REQ = 4'b0100; step();
    chk("single_pend", PENDING, 4'b0100); chk("single_noalarm_yet", ALARM, 0);
    step();
    chk("single_alarm", ALARM, 1); chk("single_grant", GRANT, 4'b0100);
    chk("single_pend_clr", PENDING, 0);
    t0 = cyc; n = 0;
    while (GRANT !== 4'b0000 && n < 6000) begin step(); n++; end
    chk("single_grant_len", cyc - t0, 1 + H);
    wait_idle("single", na);
    chk("single_busy_len", cyc - t0, 1 + H + G);
    chk("single_extra_alarms", na, 0);

    // Priority: sources 3 and 1 rise together
    REQ = 4'b0000; step();
    REQ = 4'b1010; step();
    chk("prio_pend", PENDING, 4'b1010);
    step();
    chk("prio_grant1", GRANT, 4'b0010); chk("prio_left", PENDING, 4'b1000);
    t0 = cyc;
    step();
    wait_alarm("prio2", n);
    chk("prio_spacing", cyc - t0, 1 + H + G + 1);
    chk("prio_grant3", GRANT, 4'b1000);

    // Drops: source 0 becomes pending, then three more edges
    REQ = 4'b1011; step();
    for (int i = 0; i < 3; i++) begin
      REQ[0] = 1'b0; step();
      REQ[0] = 1'b1; step();
    end
    chk("drop3_cnt", DROP_CNT, 3); chk("drop3_pend", PENDING, 4'b0001);

    // Re-request in the grant cycle of source 0
    REQ[0] = 1'b0;
    wait_idle("rereq", na);
    chk("drop_no_extra_alarm", na, 0);
    REQ[0] = 1'b1; step();
    chk("rereq_alarm", ALARM, 1); chk("rereq_grant", GRANT, 4'b0001);
    chk("rereq_pend", PENDING, 4'b0001); chk("rereq_drop", DROP_CNT, 3);

    // Saturation: 301 edges on source 1 while it is pending
    for (int i = 0; i < 301; i++) begin
      REQ[1] = 1'b0; step();
      REQ[1] = 1'b1; step();
    end
    chk("drop_sat", DROP_CNT, 255); chk("sat_pend", PENDING, 4'b0011);

    // Mask clears a pending source; unmasking with the level high is no edge
    MASK = 4'b0010; step();
    chk("mask_clr", PENDING, 4'b0001);
    MASK = 4'b0000; step();
    chk("unmask_noedge", PENDING, 4'b0001);
    wait_alarm("rereq_fire", n);
    chk("rereq_fire_grant", GRANT, 4'b0001);
    wait_idle("mask", na);
    repeat (30) begin step(); if (ALARM === 1'b1) na++; end
    chk("mask_no_alarm", na, 0); chk("mask_idle_pend", PENDING, 0);

    // Flush during HOLD: pending cleared, alarm keeps its full hold
    REQ = 4'b0000; step();
    REQ = 4'b0100; step(); step();
    chk("flush_alarm", ALARM, 1);
    t0 = cyc;
    repeat (50) step();
    REQ = 4'b1100; step();
    chk("flush_pre_pend", PENDING, 4'b1000);
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    chk("flush_pend", PENDING, 0);
    n = 0;
    while (GRANT !== 4'b0000 && n < 6000) begin step(); n++; end
    chk("flush_grant_len", cyc - t0, 1 + H);

    // Reset mid-HOLD
    REQ = 4'b0000;
    wait_idle("pre_rst", na);
    REQ = 4'b0010; step(); step();
    chk("rst_test_alarm", ALARM, 1);
    repeat (100) step();
    REQ = 4'b1010; step();
    chk("rst_test_pend", PENDING, 4'b1000);
    #2 RSTN = 1'b0;
    #1;
    chk("async_alarm", ALARM, 0); chk("async_grant", GRANT, 0);
    chk("async_busy", BUSY, 0);   chk("async_pend", PENDING, 0);
    chk("async_drop", DROP_CNT, 0);
    REQ = 4'b0000;
    repeat (3) @(posedge CLK1K);
    #3 RSTN = 1'b1;
    na = 0;
    repeat (20) begin step(); if (ALARM === 1'b1) na++; end
    chk("post_rst_idle", BUSY, 0); chk("post_rst_alarms", na, 0);

    // A level held high through reset counts as an edge at the first clock
    @(negedge CLK1K); RSTN = 1'b0; REQ = 4'b0100;
    repeat (2) @(posedge CLK1K);
    #3 RSTN = 1'b1;
    step();
    chk("held_level_edge", PENDING, 4'b0100);
    step();
    chk("held_level_alarm", ALARM, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
